dbi_rx_decoder: RTL

- Receive-side counterpart of the DC-DBI transmit encoder: takes one DQ byte-lane plus its active-low DBI_n pin per beat and restores true data by inverting every beat flagged by DBI_n.
- Assembles BURST_LEN beats into one burst word and presents it on a valid/ready output.
- Checks each received beat against the DC-DBI zero-count rule and flags violations and framing faults.
- Sits between the lane capture flops and the read-data path.

---
 rtl/dbi_pkg.sv | 14 +
 rtl/dbi_zero_count.sv | 19 +
 rtl/dbi_rx_decoder.sv | 109 ++++++++++
 3 files changed

// File: rtl/dbi_pkg.sv
// Shared definitions for the DC-DBI lane logic: default geometry, zero-count limit,
// receive FSM encoding and DBI_n polarity.
package dbi_pkg;
  localparam int DBI_DATA_W     = 8;
  localparam int DBI_BURST_LEN  = 8;
  localparam int DBI_ZERO_LIMIT = (DBI_DATA_W + 1) / 2;

  localparam logic DBI_INVERTED = 1'b0;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } rx_state_e;
endpackage

// File: rtl/dbi_zero_count.sv
// Zero-popcount over W lane lines; flags when the zero count exceeds LIMIT.
module dbi_zero_count #(
  parameter int W     = 9,
  parameter int LIMIT = 4
) (
  input  logic [W-1:0] lines,
  output logic         over_limit
);
  localparam int ZW = $clog2(W + 1);

  logic [ZW-1:0] zeros;

  always_comb begin
    zeros = '0;
    for (int i = 0; i < W; i++) zeros = zeros + ZW'(!lines[i]);
  end

  assign over_limit = zeros > ZW'(LIMIT);
endmodule

// File: rtl/dbi_rx_decoder.sv
// DC-DBI receive decoder: un-inverts flagged beats, assembles bursts into a
// valid/ready output register and reports DBI-rule and framing faults.
module dbi_rx_decoder
  import dbi_pkg::*;
#(
  parameter int DATA_W    = DBI_DATA_W,
  parameter int BURST_LEN = DBI_BURST_LEN,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        beat_valid,
  input  logic                        burst_start,
  input  logic [DATA_W-1:0]           dq_in,
  input  logic                        dbi_n_in,
  output logic [DATA_W*BURST_LEN-1:0] rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        dbi_viol,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [CNT_W-1:0]            inv_count,
  output logic [CNT_W-1:0]            viol_count
);
  localparam int IDX_W      = $clog2(BURST_LEN);
  localparam int ZERO_LIMIT = (DATA_W + 1) / 2;

  rx_state_e                         state;
  logic [IDX_W-1:0]                  beat_idx;
  logic [BURST_LEN-1:0][DATA_W-1:0]  coll_buf;
  logic                              done_q;

  logic [DATA_W-1:0] beat_data;
  logic              beat_inv;
  logic              beat_viol;
  logic              beat_store;

  assign beat_inv   = dbi_n_in == DBI_INVERTED;
  assign beat_data  = beat_inv ? ~dq_in : dq_in;
  // Orphan beats in IDLE are discarded and therefore not counted as inverted.
  assign beat_store = beat_valid && (burst_start || state == COLLECT);

  dbi_zero_count #(.W(DATA_W + 1), .LIMIT(ZERO_LIMIT)) u_zero_count (
    .lines      ({dbi_n_in, dq_in}),
    .over_limit (beat_viol)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_idx   <= '0;
      coll_buf   <= '0;
      done_q     <= 1'b0;
      dbi_viol   <= 1'b0;
      frame_err  <= 1'b0;
      inv_count  <= '0;
      viol_count <= '0;
    end else begin
      done_q    <= 1'b0;
      dbi_viol  <= 1'b0;
      frame_err <= 1'b0;
      if (beat_valid) begin
        dbi_viol <= beat_viol;
        if (beat_viol && viol_count != '1) viol_count <= viol_count + CNT_W'(1);
        if (beat_store && beat_inv && inv_count != '1) inv_count <= inv_count + CNT_W'(1);
        if (burst_start) begin
          // A start mid-burst drops the partial burst and restarts at beat 0.
          frame_err   <= state == COLLECT;
          coll_buf[0] <= beat_data;
          beat_idx    <= IDX_W'(1);
          state       <= COLLECT;
        end else if (state == IDLE) begin
          frame_err <= 1'b1;
        end else begin
          coll_buf[beat_idx] <= beat_data;
          if (beat_idx == IDX_W'(BURST_LEN - 1)) begin
            beat_idx <= '0;
            state    <= IDLE;
            done_q   <= 1'b1;
          end else begin
            beat_idx <= beat_idx + IDX_W'(1);
          end
        end
      end
    end
  end

  // Output stage runs one cycle behind completion so the collect buffer can
  // start the next burst on the very next beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= coll_buf;
          rx_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
endmodule
